// File: rtl/mio_bus_responder_if.sv
// CPU-side memory/IO handshake bundle between the pipeline MEM stage and the responder.
// The CPU holds a request until MIO_ready pulses, then drops or replaces it.
interface mio_bus_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        MIO_ready;

  modport master (
    output mem_read,
    output mem_write,
    output addr,
    output wdata,
    input  rdata,
    input  MIO_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  addr,
    input  wdata,
    output rdata,
    output MIO_ready
  );
endinterface

// File: rtl/mio_bus_responder.sv
// Memory/IO responder: serves word RAM and memory-mapped LED, switch and counter registers,
// completing each access with a one-cycle MIO_ready pulse.
module mio_bus_responder #(
  parameter int unsigned RAM_DEPTH = 1024,
  parameter int unsigned RAM_WAIT  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mio_bus_responder_if.slave  bus,
  input  logic [15:0]         switches,
  output logic [15:0]         led,
  output logic [31:0]         counter
);

  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned WW = (RAM_WAIT > 1) ? $clog2(RAM_WAIT) : 1;
  localparam logic [31:0]    RAM_BYTES = 32'(RAM_DEPTH * 4);
  localparam logic [29:0]    LED_WA    = 30'h3FFF_FFC0;
  localparam logic [29:0]    SW_WA     = 30'h3FFF_FFC1;
  localparam logic [29:0]    CNT_WA    = 30'h3FFF_FFC2;
  localparam logic [WW-1:0]  WAIT_LOAD = WW'(RAM_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef enum logic [2:0] {
    R_RAM,
    R_LED,
    R_SW,
    R_CNT,
    R_NONE
  } region_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  region_e         region_q, region_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [15:0]     led_q, led_d;
  logic [31:0]     counter_q, counter_d;

  logic            req;
  region_e         req_region;
  logic [31:0]     periph_rd;
  logic [31:0]     ram_rd;
  logic            commit;
  logic            ram_we;

  logic [31:0]     ram [RAM_DEPTH];

  // Address decode of the live request; only consulted while IDLE.
  always_comb begin
    req        = bus.mem_read | bus.mem_write;
    req_region = R_NONE;
    if (bus.addr < RAM_BYTES) begin
      req_region = R_RAM;
    end else if (bus.addr[31:2] == LED_WA) begin
      req_region = R_LED;
    end else if (bus.addr[31:2] == SW_WA) begin
      req_region = R_SW;
    end else if (bus.addr[31:2] == CNT_WA) begin
      req_region = R_CNT;
    end
  end

  // The counter read returns the value it shows during the RESP cycle.
  always_comb begin
    periph_rd = 32'h0;
    case (req_region)
      R_LED:   periph_rd = {16'h0, led_q};
      R_SW:    periph_rd = {16'h0, switches};
      R_CNT:   periph_rd = counter_q + 32'd1;
      default: periph_rd = 32'h0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    region_d = region_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          region_d = req_region;
          wr_d     = bus.mem_write;
          idx_d    = bus.addr[AW+1:2];
          wdata_d  = bus.wdata;
          if (req_region == R_RAM) begin
            state_d = S_WAIT;
            wcnt_d  = WAIT_LOAD;
          end else begin
            state_d = S_RESP;
            rdata_d = bus.mem_write ? 32'h0 : periph_rd;
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == '0) begin
          state_d = S_RESP;
          rdata_d = wr_q ? 32'h0 : ram_rd;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Writes land only on the edge that closes RESP, so a reset before then drops them.
  assign commit = rst_n && (state_q == S_RESP) && wr_q;
  assign ram_we = commit && (region_q == R_RAM);

  always_comb begin
    led_d     = led_q;
    counter_d = counter_q + 32'd1;
    if (commit && (region_q == R_LED)) begin
      led_d = wdata_q[15:0];
    end
    if (commit && (region_q == R_CNT)) begin
      counter_d = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      rdata_q   <= 32'h0;
      led_q     <= 16'h0;
      counter_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      counter_q <= counter_d;
    end
  end

  always_ff @(posedge clk) begin
    region_q <= region_d;
    wr_q     <= wr_d;
    idx_q    <= idx_d;
    wdata_q  <= wdata_d;
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[idx_q] <= wdata_q;
    end
  end

  assign ram_rd        = ram[idx_q];
  assign bus.rdata     = rdata_q;
  assign bus.MIO_ready = (state_q == S_RESP);
  assign led           = led_q;
  assign counter       = counter_q;

endmodule

// File: doc/mio_bus_responder.md
# mio_bus_responder

Memory/IO responder at the far end of the CPU's `MIO_ready` handshake. It accepts load/store requests from the pipeline MEM stage and serves them from an internal word RAM or a small set of memory-mapped peripherals (LED register, switch input, free-running counter). It asserts `MIO_ready` for exactly one cycle when each access completes; the CPU stalls its MEM stage until then.

## Interface
- `RAM_DEPTH`, 1024: RAM size in 32-bit words; power of two.
- `RAM_WAIT`, 2: wait cycles for a RAM access, ≥1.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `mem_read`  in  1  load request; held by the CPU until `MIO_ready`.
- `mem_write`  in  1  store request; held by the CPU until `MIO_ready`.
- `addr`  in  32  byte address; bits [1:0] ignored.
- `wdata`  in  32  store data; stable while the request is held.
- `switches`  in  16  board switch levels.
- `rdata`  out  32  load data; valid in the `MIO_ready` cycle.
- `MIO_ready`  out  1  one-cycle completion pulse.
- `led`  out  16  LED register.
- `counter`  out  32  free-running counter value.

## Operation
- Address map:
  - RAM: `addr < RAM_DEPTH*4`. Word index is `addr[log2(RAM_DEPTH)+1:2]`.
  - LED: 0xFFFF_FF00, R/W. Write takes `wdata[15:0]`; read returns zero-extended `led`.
  - Switches: 0xFFFF_FF04, read-only. Returns zero-extended `switches`; writes are dropped.
  - Counter: 0xFFFF_FF08, R/W.
  - Anything else is unmapped: reads return 0, writes are dropped.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, no request: stay in IDLE.
  - IDLE, request to RAM: go to WAIT and load the wait counter with `RAM_WAIT-1`.
  - IDLE, request to peripheral or unmapped: go to RESP.
  - WAIT: decrement the counter each cycle; go to RESP when it reaches 0.
  - RESP: assert `MIO_ready`, drive `rdata`, commit any write, return to IDLE.
- Address, data and type are latched in IDLE when a request is accepted. Input changes after acceptance are ignored.
- `mem_read` and `mem_write` both high: treated as a write.
- The CPU drops or replaces its request in the cycle after `MIO_ready`. A request present in IDLE is always a new access, so back-to-back requests are allowed.
- Counter:
  - Increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
  - A write in RESP loads `wdata`, which replaces the increment for that cycle. The value is `wdata+1` one cycle later.
  - A read returns the counter value registered at the RESP edge.
- RAM contents are not reset. RAM writes are word-wide only.

## Timing
- Reset values: state IDLE, `MIO_ready` 0, `rdata` 0, `led` 0, `counter` 0, wait counter 0.
- Reset mid-access aborts it. No `MIO_ready` is issued, and an uncommitted write is lost; all writes commit only in RESP.
- Latency counts from the request being high in IDLE at edge N:
  - Peripheral or unmapped: `MIO_ready` high in cycle N+1 (2-cycle access).
  - RAM: `MIO_ready` high in cycle N+1+`RAM_WAIT`.
- `MIO_ready` is high for exactly one cycle per accepted request and never without one.
- `rdata` is registered. It holds its last value outside RESP and is 0 after a write or unmapped read.
- Maximum throughput is one peripheral access every 2 cycles.

## Test plan
- Reset, then idle for 10 cycles: `MIO_ready`=0, `led`=0, `counter`=10.
- Write 0xDEADBEEF to RAM 0x10 (`RAM_WAIT`=2), then read 0x10: write `MIO_ready` 3 cycles after request; read returns 0xDEADBEEF with `MIO_ready` 3 cycles after request.
- Write 0x0001_A5A5 to 0xFFFF_FF00, then read it back: `led`=0xA5A5 after RESP; read `rdata`=0x0000_A5A5.
- `switches`=0x1234, read 0xFFFF_FF04 → `rdata`=0x0000_1234; write to 0xFFFF_FF04 and to 0x8000_0000 → `MIO_ready` pulses, no state change; read 0x8000_0000 → 0.
- Write 0xFFFF_FFFE to the counter: `counter` sequence is 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- RAM write to 0x20 with `rst_n` low during WAIT: no `MIO_ready`; after reset, read 0x20 returns its previous contents.
